psum_accum: RTL and testbench
=============================

PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 24, meaning the accumulator width per lane.
REQ-002 SHALL have parameter LEN_W, default 8, meaning the width of the accumulation-length field.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, which begins an accumulation run.
REQ-006 SHALL have port acc_len, input, LEN_W, the number of psums per run; sampled on an accepted start.
REQ-007 SHALL have port weight_width, input, 3, the packing mode; sampled on an accepted start.
REQ-008 SHALL have port signed_mode, input, 1, equal to the producer's s_in|s_weight; sampled on an accepted start.
REQ-009 SHALL have port psum_in, input, 18, the registered psum_fwd word from a fusion unit.
REQ-010 SHALL have port psum_valid, input, 1, which qualifies psum_in.
REQ-011 SHALL have port acc0, output, ACC_W, the lane-0 result.
REQ-012 SHALL have port acc1, output, ACC_W, the lane-1 result.
REQ-013 SHALL have port out_valid, output, 1, which flags that results are held.
REQ-014 SHALL have port out_ready, input, 1, the consumer accept.
REQ-015 SHALL have port busy, output, 1, high in ACCUM.
REQ-016 SHALL have port drop_err, output, 1, a sticky flag for discarded psums.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-018 In IDLE, start SHALL latch mode, signed_mode and acc_len, clear both accumulators and the count, and go to ACCUM next cycle.
REQ-019 If acc_len==0, start SHALL go to HOLD directly with acc0=acc1=0.
REQ-020 Split mode (latched weight_width[1]|weight_width[0]) SHALL take lane0=psum_in[8:0] and lane1=psum_in[17:9]; each lane SHALL be sign-extended to ACC_W if signed_mode, otherwise zero-extended.
REQ-021 Single mode SHALL take lane0=psum_in[17:0], extended per signed_mode; lane1 SHALL contribute 0, and acc1 SHALL stay 0.
REQ-022 In ACCUM, each cycle with psum_valid SHALL add the lanes into the accumulators and increment the count; arithmetic SHALL wrap modulo 2^ACC_W.
REQ-023 The psum that makes the count equal acc_len SHALL be included, and the FSM SHALL enter HOLD the next cycle with out_valid=1 and final sums on acc0/acc1 (accept-to-valid latency 1 cycle).
REQ-024 In HOLD, acc0, acc1 and out_valid SHALL stay stable until out_ready=1; that cycle completes the transfer, and the FSM SHALL go to IDLE next cycle.
REQ-025 A start in ACCUM or HOLD, including a start coincident with out_ready, SHALL be ignored.
REQ-026 psum_valid in IDLE or HOLD SHALL be discarded and set drop_err=1; drop_err SHALL clear only on rst or an accepted start.
REQ-027 Cycles in ACCUM without psum_valid SHALL leave the state unchanged; there is no timeout.

Reset
REQ-028 rst SHALL force IDLE, acc0=acc1=0, count=0, out_valid=0, busy=0 and drop_err=0 on the next edge, overriding all other inputs.
REQ-029 rst asserted mid-ACCUM or mid-HOLD SHALL abandon the run with no output produced.

Structure
REQ-030 Shared package fusion_pkg SHALL hold PSUM_W=18, LANE_W=9, the default ACC_W, and the state enum.
REQ-031 Unpack and extension logic SHALL live in one combinational sub-module, psum_unpack.
REQ-032 Accumulators SHALL be registered, with no combinational path from psum_in to the outputs.

Verification
REQ-033 Split signed: weight_width=3'b001, signed_mode=1, acc_len=3, psum_in={9'h1FF,9'h002} x3 -> acc0=24'h000006, acc1=24'hFFFFFD, out_valid 1 cycle after the 3rd valid.
REQ-034 Single unsigned: weight_width=3'b100, signed_mode=0, acc_len=2, psum_in=18'h3FFFF x2 -> acc0=24'h07FFFE, acc1=0.
REQ-035 Single signed with gaps: acc_len=4, psum_in=18'h3FFFF on valid cycles separated by idle cycles -> acc0=24'hFFFFFC.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in HOLD -> outputs stable; a start plus psum_valid pulse there -> start ignored, drop_err=1.
REQ-037 acc_len=0 start -> HOLD next cycle, acc0=acc1=0, out_valid=1.
REQ-038 rst asserted after 2 of 4 psums -> IDLE, all outputs 0; a new run of 1 psum 18'h00005 -> acc0=5.

Source files
------------

// File: rtl/fusion_pkg.sv
// Shared constants and types for the fusion-unit psum path.
// The accumulator FSM state encoding and the packing-mode decode live here.
package fusion_pkg;

  localparam int PSUM_W        = 18;
  localparam int LANE_W        = 9;
  localparam int ACC_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Any weight width with a non-zero low pair packs two 9-bit lanes per word.
  function automatic logic is_split(input logic [2:0] ww);
    case (ww)
      3'b000, 3'b100: is_split = 1'b0;
      default:        is_split = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/psum_unpack.sv
// Combinational unpack of one psum word into two lane addends,
// sign- or zero-extended to the accumulator width.
module psum_unpack
  import fusion_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic [PSUM_W-1:0]       i_psum,
  input  logic                    i_split,
  input  logic                    i_sgn,
  output logic signed [ACC_W-1:0] o_lane0,
  output logic signed [ACC_W-1:0] o_lane1
);

  logic [LANE_W-1:0] w_lo;
  logic [LANE_W-1:0] w_hi;
  logic              w_lo_msb;
  logic              w_hi_msb;
  logic              w_full_msb;

  assign w_lo       = i_psum[LANE_W-1:0];
  assign w_hi       = i_psum[PSUM_W-1:LANE_W];
  assign w_lo_msb   = i_sgn & w_lo[LANE_W-1];
  assign w_hi_msb   = i_sgn & w_hi[LANE_W-1];
  assign w_full_msb = i_sgn & i_psum[PSUM_W-1];

  always_comb begin
    o_lane0 = '0;
    o_lane1 = '0;
    if (i_split) begin
      o_lane0 = {{(ACC_W-LANE_W){w_lo_msb}}, w_lo};
      o_lane1 = {{(ACC_W-LANE_W){w_hi_msb}}, w_hi};
    end else begin
      o_lane0 = {{(ACC_W-PSUM_W){w_full_msb}}, i_psum};
    end
  end

endmodule

// File: rtl/psum_accum.sv
// Two-lane psum accumulator: collects acc_len psums per run, then holds
// the sums with a valid/ready handshake until the consumer takes them.
module psum_accum
  import fusion_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic [2:0]        weight_width,
  input  logic              signed_mode,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  output logic [ACC_W-1:0]  acc0,
  output logic [ACC_W-1:0]  acc1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              drop_err
);

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc0;
  logic signed [ACC_W-1:0] r_acc1;
  logic [LEN_W-1:0]        r_cnt;
  logic [LEN_W-1:0]        r_len;
  logic                    r_split;
  logic                    r_sgn;
  logic                    r_out_valid;
  logic                    r_busy;
  logic                    r_drop;

  logic signed [ACC_W-1:0] w_lane0;
  logic signed [ACC_W-1:0] w_lane1;
  logic [LEN_W-1:0]        w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + LEN_W'(1);

  psum_unpack #(.ACC_W(ACC_W)) u_unpack (
    .i_psum  (psum_in),
    .i_split (r_split),
    .i_sgn   (r_sgn),
    .o_lane0 (w_lane0),
    .o_lane1 (w_lane1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc0      <= '0;
      r_acc1      <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_split     <= 1'b0;
      r_sgn       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len   <= acc_len;
            r_split <= is_split(weight_width);
            r_sgn   <= signed_mode;
            r_acc0  <= '0;
            r_acc1  <= '0;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
            if (acc_len == '0) begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
              r_busy  <= 1'b1;
            end
          end
          // A stray psum is still an error even when it coincides with start.
          if (psum_valid) r_drop <= 1'b1;
        end
        ST_ACCUM: begin
          if (psum_valid) begin
            r_acc0 <= r_acc0 + w_lane0;
            r_acc1 <= r_acc1 + w_lane1;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              r_state     <= ST_HOLD;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (psum_valid) r_drop <= 1'b1;
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign acc0      = r_acc0;
  assign acc1      = r_acc1;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: a run-level reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_psum_accum;

  localparam int ACC_W = 24;
  localparam int LEN_W = 8;
  localparam longint MASK = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] acc_len = '0;
  logic [2:0]       weight_width = '0;
  logic             signed_mode = 1'b0;
  logic [17:0]      psum_in = '0;
  logic             psum_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc0;
  logic [ACC_W-1:0] acc1;
  logic             out_valid;
  logic             busy;
  logic             drop_err;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  psum_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .acc_len      (acc_len),
    .weight_width (weight_width),
    .signed_mode  (signed_mode),
    .psum_in      (psum_in),
    .psum_valid   (psum_valid),
    .acc0         (acc0),
    .acc1         (acc1),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .drop_err     (drop_err)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 results offered.
  int     m_ph = 0;
  longint m_s0 = 0;
  longint m_s1 = 0;
  int     m_cnt = 0;
  int     m_len = 0;
  bit     m_split = 0;
  bit     m_sgn = 0;
  bit     m_drop = 0;

  function automatic longint ext(input longint v, input int w, input bit s);
    if (s && v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_s0 = 0; m_s1 = 0; m_cnt = 0; m_drop = 0;
    end else if (m_ph == 0) begin
      if (start) begin
        m_len   = int'(acc_len);
        m_split = weight_width[1] | weight_width[0];
        m_sgn   = signed_mode;
        m_s0 = 0; m_s1 = 0; m_cnt = 0; m_drop = 0;
        m_ph = (m_len == 0) ? 2 : 1;
      end
      if (psum_valid) m_drop = 1;
    end else if (m_ph == 1) begin
      if (psum_valid) begin
        if (m_split) begin
          m_s0 += ext(longint'(psum_in[8:0]), 9, m_sgn);
          m_s1 += ext(longint'(psum_in[17:9]), 9, m_sgn);
        end else begin
          m_s0 += ext(longint'(psum_in), 18, m_sgn);
        end
        m_cnt++;
        if (m_cnt == m_len) m_ph = 2;
      end
    end else begin
      if (psum_valid) m_drop = 1;
      if (out_ready) m_ph = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", longint'(out_valid), longint'(m_ph == 2));
      chk("busy", longint'(busy), longint'(m_ph == 1));
      chk("drop_err", longint'(drop_err), longint'(m_drop));
      chk("acc0", longint'(acc0), m_s0 & MASK);
      chk("acc1", longint'(acc1), m_s1 & MASK);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int len, input logic [2:0] ww, input logic sm);
    start = 1'b1; acc_len = LEN_W'(len); weight_width = ww; signed_mode = sm;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [17:0] v, input int gap);
    psum_valid = 1'b1; psum_in = v;
    cyc();
    psum_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset acc0", longint'(acc0), 0);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset drop_err", longint'(drop_err), 0);

    // Split signed, three back-to-back psums.
    start_run(3, 3'b001, 1'b1);
    repeat (3) send({9'h1FF, 9'h002}, 0);
    chk("split acc0", longint'(acc0), 64'h000006);
    chk("split acc1", longint'(acc1), 64'hFFFFFD);
    chk("split out_valid", longint'(out_valid), 1);
    release_out();
    chk("split done", longint'(out_valid), 0);

    // Single unsigned.
    start_run(2, 3'b100, 1'b0);
    repeat (2) send(18'h3FFFF, 0);
    chk("single u acc0", longint'(acc0), 64'h07FFFE);
    chk("single u acc1", longint'(acc1), 0);
    release_out();

    // Single signed with idle gaps, then backpressure in HOLD.
    start_run(4, 3'b100, 1'b1);
    send(18'h3FFFF, 1);
    send(18'h3FFFF, 2);
    send(18'h3FFFF, 1);
    send(18'h3FFFF, 0);
    chk("gaps acc0", longint'(acc0), 64'hFFFFFC);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold acc0", longint'(acc0), 64'hFFFFFC);
      chk("hold out_valid", longint'(out_valid), 1);
    end
    start = 1'b1; psum_valid = 1'b1; psum_in = 18'h00001;
    cyc();
    start = 1'b0; psum_valid = 1'b0;
    chk("hold drop_err", longint'(drop_err), 1);
    chk("hold start ignored", longint'(busy), 0);
    chk("hold acc0 kept", longint'(acc0), 64'hFFFFFC);
    start = 1'b1; acc_len = 8'd2; out_ready = 1'b1;
    cyc();
    start = 1'b0; out_ready = 1'b0;
    chk("ready+start valid", longint'(out_valid), 0);
    chk("ready+start busy", longint'(busy), 0);
    chk("drop sticky", longint'(drop_err), 1);

    // Zero-length run goes straight to HOLD and clears drop_err.
    start_run(0, 3'b001, 1'b1);
    chk("len0 out_valid", longint'(out_valid), 1);
    chk("len0 acc0", longint'(acc0), 0);
    chk("len0 acc1", longint'(acc1), 0);
    chk("len0 drop_err", longint'(drop_err), 0);
    release_out();

    // Reset in the middle of a run, then a one-psum run.
    start_run(4, 3'b001, 1'b0);
    send(18'h00403, 0);
    send(18'h00403, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst acc0", longint'(acc0), 0);
    chk("rst acc1", longint'(acc1), 0);
    chk("rst busy", longint'(busy), 0);
    chk("rst out_valid", longint'(out_valid), 0);
    start_run(1, 3'b100, 1'b0);
    send(18'h00005, 0);
    chk("after rst acc0", longint'(acc0), 5);
    chk("after rst out_valid", longint'(out_valid), 1);
    release_out();
    repeat (2) cyc();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
